// File: rtl/nibble_serial_addsub_ctrl_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer:
// FSM state encodings, slice width and a clog2 helper (minimum result 1).
package nibble_serial_addsub_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int NIBBLE_W = 4;

  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/nibble_add4.sv
// Combinational 4-bit ripple-carry adder slice built from NAND-only
// full-adder cells (nine NAND2 gates per bit).
module nibble_add4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] c;
  logic [3:0] n1, n2, n3, x1, n4, n5, n6;

  assign c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign n1[i]  = ~(a[i] & b[i]);
    assign n2[i]  = ~(a[i] & n1[i]);
    assign n3[i]  = ~(b[i] & n1[i]);
    assign x1[i]  = ~(n2[i] & n3[i]);
    assign n4[i]  = ~(x1[i] & c[i]);
    assign n5[i]  = ~(x1[i] & n4[i]);
    assign n6[i]  = ~(c[i] & n4[i]);
    assign s[i]   = ~(n5[i] & n6[i]);
    assign c[i+1] = ~(n1[i] & n4[i]);
  end

  assign cout = c[4];

endmodule

// File: rtl/nibble_serial_addsub_ctrl.sv
// Nibble-serial add/subtract sequencer sharing one 4-bit adder slice, LS nibble first.
// Optional zero-result flag output enabled by NIBBLE_SERIAL_ZERO_FLAG_EN.
module nibble_serial_addsub_ctrl
  import nibble_serial_addsub_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  input  logic                    sub,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0] result,
  output logic                    cout,
  output logic                    overflow
`ifdef NIBBLE_SERIAL_ZERO_FLAG_EN
  ,
  output logic                    zero
`endif
);

  localparam int W    = NIBBLE_W * NIBBLES;
  localparam int IDXW = clog2_min1(NIBBLES);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NIBBLES - 1);

  state_e          state_q;
  logic [W-1:0]    opa_q, opb_q, result_q;
  logic            carry_q, cout_q, ovf_q, in_ready_q, out_valid_q;
  logic [IDXW-1:0] idx_q, idx_d;
`ifdef NIBBLE_SERIAL_ZERO_FLAG_EN
  logic            zero_q;
`endif

  logic [NIBBLE_W-1:0] nib_a, nib_b, nib_s;
  logic                nib_c;

  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int unsigned n = 0; n < NIBBLES; n++) begin
      if (idx_q == IDXW'(n)) begin
        nib_a = opa_q[n*NIBBLE_W +: NIBBLE_W];
        nib_b = opb_q[n*NIBBLE_W +: NIBBLE_W];
      end
    end
    idx_d = idx_q + IDXW'(1);
  end

  nibble_add4 u_slice (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry_q),
    .s    (nib_s),
    .cout (nib_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      opa_q       <= '0;
      opb_q       <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
`ifdef NIBBLE_SERIAL_ZERO_FLAG_EN
      zero_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            // Subtraction is A + ~B + 1: invert B here and seed the carry with 1.
            opa_q      <= a;
            opb_q      <= sub ? ~b : b;
            carry_q    <= sub;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ST_RUN;
`ifdef NIBBLE_SERIAL_ZERO_FLAG_EN
            zero_q     <= 1'b1;
`endif
          end
        end
        ST_RUN: begin
          for (int unsigned n = 0; n < NIBBLES; n++) begin
            if (idx_q == IDXW'(n)) result_q[n*NIBBLE_W +: NIBBLE_W] <= nib_s;
          end
          carry_q <= nib_c;
`ifdef NIBBLE_SERIAL_ZERO_FLAG_EN
          zero_q  <= zero_q & (nib_s == '0);
`endif
          if (idx_q == IDX_LAST) begin
            cout_q      <= nib_c;
            ovf_q       <= (opa_q[W-1] == opb_q[W-1]) && (nib_s[NIBBLE_W-1] != opa_q[W-1]);
            idx_q       <= '0;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            idx_q <= idx_d;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;
`ifdef NIBBLE_SERIAL_ZERO_FLAG_EN
  assign zero      = zero_q;
`endif

endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// Self-checking bench for nibble_serial_addsub_ctrl: directed vector table,
// multi-cycle corner sequences and randomized ops against an arithmetic model.
module tb_nibble_serial_addsub_ctrl;

  localparam int N0 = 4;
  localparam int N1 = 1;

  logic        clk = 1'b0;
  logic        rst;

  logic        in_valid, in_ready, sub, out_valid, out_ready, cout, overflow;
  logic [15:0] a, b, result;
`ifdef NIBBLE_SERIAL_ZERO_FLAG_EN
  logic        zero;
`endif

  logic        in_valid1, in_ready1, sub1, out_valid1, out_ready1, cout1, overflow1;
  logic [3:0]  a1, b1, result1;
`ifdef NIBBLE_SERIAL_ZERO_FLAG_EN
  logic        zero1;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  nibble_serial_addsub_ctrl #(.NIBBLES(N0)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .overflow  (overflow)
`ifdef NIBBLE_SERIAL_ZERO_FLAG_EN
    ,
    .zero      (zero)
`endif
  );

  nibble_serial_addsub_ctrl #(.NIBBLES(N1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .a         (a1),
    .b         (b1),
    .sub       (sub1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .result    (result1),
    .cout      (cout1),
    .overflow  (overflow1)
`ifdef NIBBLE_SERIAL_ZERO_FLAG_EN
    ,
    .zero      (zero1)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference: integer arithmetic on w-bit operands; returns {overflow, cout, result}.
  function automatic logic [17:0] model(input logic [15:0] av, input logic [15:0] bv,
                                        input logic sv, input int w);
    longint m, ua, ub, r, sa, sb, sr;
    logic   c, v;
    m  = longint'(1) << w;
    ua = longint'(av);
    ub = longint'(bv);
    if (sv) begin
      r = ua - ub;
      c = (ua >= ub);
    end else begin
      r = ua + ub;
      c = (r >= m);
    end
    r  = ((r % m) + m) % m;
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    sr = sv ? sa - sb : sa + sb;
    v  = (sr >= m / 2) || (sr < -(m / 2));
    return {v, c, 16'(r)};
  endfunction

  task automatic do_op(input logic [15:0] av, input logic [15:0] bv, input logic sv,
                       input int hold, input logic [15:0] er, input logic ec,
                       input logic ev, input string tag);
    int cyc;
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    check({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
    a = av; b = bv; sub = sv; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
    cyc = 0;
    while (cyc <= 20) begin
      if (out_valid) break;
      check({tag, "_in_ready_run"}, 32'(in_ready), 32'd0);
      @(posedge clk); #1; cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(N0));
    check({tag, "_result"}, 32'(result), 32'(er));
    check({tag, "_cout"}, 32'(cout), 32'(ec));
    check({tag, "_overflow"}, 32'(overflow), 32'(ev));
`ifdef NIBBLE_SERIAL_ZERO_FLAG_EN
    check({tag, "_zero"}, 32'(zero), 32'(er == 16'h0));
`endif
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom); a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
      check({tag, "_hold_stable"}, {14'd0, overflow, cout, result}, {14'd0, ev, ec, er});
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_release_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_release_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic do_op1(input logic [3:0] av, input logic [3:0] bv, input logic sv,
                        input string tag);
    logic [17:0] e;
    e = model({12'd0, av}, {12'd0, bv}, sv, 4);
    check({tag, "_in_ready_idle"}, 32'(in_ready1), 32'd1);
    a1 = av; b1 = bv; sub1 = sv; in_valid1 = 1'b1; out_ready1 = 1'b0;
    @(posedge clk); #1;
    in_valid1 = 1'b0; a1 = 4'($urandom); b1 = 4'($urandom);
    check({tag, "_valid_early"}, 32'(out_valid1), 32'd0);
    @(posedge clk); #1;
    check({tag, "_valid"}, 32'(out_valid1), 32'd1);
    check({tag, "_result"}, {14'd0, overflow1, cout1, 12'd0, result1}, {14'd0, e[17:16], 12'd0, e[3:0]});
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    out_ready1 = 1'b0;
    check({tag, "_release"}, {30'd0, out_valid1, in_ready1}, 32'd1);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    int          hold;
    logic [15:0] r;
    logic        c;
    logic        v;
  } vec_t;

  vec_t tbl [7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
    $fatal(1);
  end

  initial begin
    logic [17:0] e;
    logic [15:0] ra, rb;
    logic        rs;
    int          seen;

    tbl[0] = '{16'h1234, 16'h0FCC, 1'b0, 0,  16'h2200, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 0,  16'h0000, 1'b1, 1'b0};
    tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 1,  16'h8000, 1'b0, 1'b1};
    tbl[3] = '{16'h0005, 16'h0007, 1'b1, 0,  16'hFFFE, 1'b0, 1'b0};
    tbl[4] = '{16'h8000, 16'h0001, 1'b1, 10, 16'h7FFF, 1'b1, 1'b1};
    tbl[5] = '{16'h00F0, 16'hFF10, 1'b0, 2,  16'h0000, 1'b1, 1'b0};
    tbl[6] = '{16'h0001, 16'h0000, 1'b0, 0,  16'h0001, 1'b0, 1'b0};

    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b0;
    in_valid1 = 1'b0; a1 = '0; b1 = '0; sub1 = 1'b0; out_ready1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_outputs", {15'd0, overflow, cout, result}, 32'd0);
    check("reset_dut1", {26'd0, in_ready1, out_valid1, result1}, 32'h20);
    rst = 1'b0;

    for (int i = 0; i < 7; i++)
      do_op(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].hold, tbl[i].r, tbl[i].c, tbl[i].v,
            $sformatf("vec%0d", i));

    // Reset during the second RUN cycle discards the operation.
    a = 16'h4321; b = 16'h1111; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_run_out_valid", 32'(out_valid), 32'd0);
    check("rst_run_in_ready", 32'(in_ready), 32'd1);
    check("rst_run_outputs", {15'd0, overflow, cout, result}, 32'd0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("rst_run_no_output", 32'(seen), 32'd0);
    do_op(16'h0001, 16'h0001, 1'b0, 0, 16'h0002, 1'b0, 1'b0, "post_rst");

    // Reset while holding a result in DONE.
    a = 16'hFFFF; b = 16'hFFFF; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (N0 + 2) @(posedge clk);
    #1;
    check("pre_rst_done_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_done_state", {30'd0, out_valid, in_ready}, 32'd1);
    check("rst_done_outputs", {15'd0, overflow, cout, result}, 32'd0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       ra = 16'h7FFF;
        1:       ra = 16'h8000;
        default: ra = 16'($urandom);
      endcase
      rb = (i % 5 == 0) ? ra : 16'($urandom);
      rs = 1'($urandom);
      e  = model(ra, rb, rs, 16);
      do_op(ra, rb, rs, int'($urandom_range(0, 3)), e[15:0], e[16], e[17],
            $sformatf("rnd%0d", i));
    end

    do_op1(4'h9, 4'h8, 1'b0, "n1_9p8");
    check("n1_9p8_exact", {27'd0, overflow1, cout1, result1}, 32'h31);
    do_op1(4'h0, 4'h1, 1'b1, "n1_0m1");
    for (int i = 0; i < 16; i++)
      do_op1(4'($urandom), 4'($urandom), 1'($urandom), $sformatf("n1_rnd%0d", i));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
